// File: rtl/ptngen_multi_if.sv
// Video-path bundle between the timing counter, the pattern generator and the
// DAC/encoder: counts and pattern controls in, pixel colour and DE out.
interface ptngen_multi_if #(
  parameter int CNT_W   = 10,
  parameter int COLOR_W = 8
);
  logic [CNT_W-1:0]     VCNT;
  logic [CNT_W-1:0]     HCNT;
  logic [2:0]           MODE;
  logic [3*COLOR_W-1:0] SOLID_RGB;
  logic [COLOR_W-1:0]   VGA_R;
  logic [COLOR_W-1:0]   VGA_G;
  logic [COLOR_W-1:0]   VGA_B;
  logic                 DE_OUT;

  modport master (
    output VCNT, HCNT, MODE, SOLID_RGB,
    input  VGA_R, VGA_G, VGA_B, DE_OUT
  );

  modport slave (
    input  VCNT, HCNT, MODE, SOLID_RGB,
    output VGA_R, VGA_G, VGA_B, DE_OUT
  );
endinterface

// File: rtl/ptngen_multi.sv
// Multi-pattern video test generator: bars, gray ramp, checker, scrolling bars,
// solid colour. Divider-free running counters, two-stage pipeline to RGB/DE.
module ptngen_multi #(
  parameter int CNT_W       = 10,
  parameter int COLOR_W     = 8,
  parameter int H_BLANK     = 144,
  parameter int H_TOTAL     = 800,
  parameter int V_BLANK     = 35,
  parameter int V_TOTAL     = 525,
  parameter int NUM_BARS    = 8,
  parameter int V_BANDS     = 4,
  parameter int CHK_LOG2    = 5,
  parameter int SCROLL_STEP = 2
) (
  input  logic           PCK,
  input  logic           RST_N,
  ptngen_multi_if.slave  vid
);

  localparam int H_ACT  = H_TOTAL - H_BLANK;
  localparam int V_ACT  = V_TOTAL - V_BLANK;
  localparam int BAR_W  = H_ACT / NUM_BARS;
  localparam int BAND_H = V_ACT / V_BANDS;
  localparam int GINC_Q = (2 ** COLOR_W) / H_ACT;
  localparam int GINC_R = (2 ** COLOR_W) % H_ACT;
  localparam int RGB_W  = 3 * COLOR_W;
  localparam int A_W    = CNT_W + 1;
  localparam int G_W    = COLOR_W + 2;

  typedef struct packed {
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
  } span_t;

  typedef struct packed {
    logic [CNT_W-1:0] pos;
    span_t            bar;
  } scr_t;

  // Index advances every `span` steps and parks on `last`, so remainders widen the last span.
  function automatic span_t span_step(span_t s, int span, int last);
    span_t n;
    n = s;
    if (s.cnt == CNT_W'(span - 1) && s.idx != CNT_W'(last)) begin
      n.idx = s.idx + CNT_W'(1);
      n.cnt = '0;
    end else begin
      n.cnt = s.cnt + CNT_W'(1);
    end
    return n;
  endfunction

  function automatic scr_t scr_step(scr_t s);
    scr_t n;
    if (s.pos == CNT_W'(H_ACT - 1)) begin
      n = '0;
    end else begin
      n.pos = s.pos + CNT_W'(1);
      n.bar = span_step(s.bar, BAR_W, NUM_BARS - 1);
    end
    return n;
  endfunction

  function automatic logic [RGB_W-1:0] bar_rgb(logic [2:0] idx, logic inv);
    logic [2:0] c;
    c = ~idx ^ {3{inv}};
    return {{COLOR_W{c[2]}}, {COLOR_W{c[1]}}, {COLOR_W{c[0]}}};
  endfunction

  function automatic logic [COLOR_W-1:0] sat_gray(logic [G_W-1:0] g);
    if (g > {2'b00, {COLOR_W{1'b1}}}) return {COLOR_W{1'b1}};
    return g[COLOR_W-1:0];
  endfunction

  logic [CNT_W-1:0] hcnt, vcnt;
  logic             act, hstart, line_st, fs, chk;

  logic [2:0]       mode_q, mode_d;
  logic [RGB_W-1:0] solid_q, solid_d;
  scr_t             off_q, off_d, scr_q, scr_d, scr_cur;
  span_t            bar_q, bar_d, bar_cur, band_q, band_d, band_cur;
  logic [A_W-1:0]   acc_q, acc_d, acc_cur, acc_sum;
  logic [G_W-1:0]   gray_q, gray_d, gray_cur;
  logic [RGB_W-1:0] pat_p1_q, pat_p1_d, rgb_p2_q, rgb_p2_d;
  logic             act_p1_q, act_p1_d, de_p2_q, de_p2_d;

  assign hcnt = vid.HCNT;
  assign vcnt = vid.VCNT;

  always_comb begin
    act = ({1'b0, hcnt} >= A_W'(H_BLANK)) && ({1'b0, hcnt} < A_W'(H_TOTAL)) &&
          ({1'b0, vcnt} >= A_W'(V_BLANK)) && ({1'b0, vcnt} < A_W'(V_TOTAL));
    hstart  = (hcnt == CNT_W'(H_BLANK));
    line_st = hstart && ({1'b0, vcnt} >= A_W'(V_BLANK)) && ({1'b0, vcnt} < A_W'(V_TOTAL));
    fs      = (hcnt == '0) && (vcnt == '0);
    chk     = (|((hcnt - CNT_W'(H_BLANK)) & CNT_W'(1 << CHK_LOG2))) ^
              (|((vcnt - CNT_W'(V_BLANK)) & CNT_W'(1 << CHK_LOG2)));
  end

  always_comb begin
    mode_d  = mode_q;
    solid_d = solid_q;
    off_d   = off_q;
    if (fs) begin
      mode_d  = vid.MODE;
      solid_d = vid.SOLID_RGB;
      for (int i = 0; i < SCROLL_STEP; i++) off_d = scr_step(off_d);
    end

    // Counters hold the state of the pixel now on HCNT; line start substitutes the initial values.
    bar_cur  = hstart ? '0 : bar_q;
    scr_cur  = hstart ? off_q : scr_q;
    acc_cur  = hstart ? '0 : acc_q;
    gray_cur = hstart ? '0 : gray_q;
    bar_d    = act ? span_step(bar_cur, BAR_W, NUM_BARS - 1) : bar_cur;
    scr_d    = act ? scr_step(scr_cur) : scr_cur;

    acc_sum = acc_cur + A_W'(GINC_R);
    acc_d   = acc_cur;
    gray_d  = gray_cur;
    if (act) begin
      if (acc_sum >= A_W'(H_ACT)) begin
        acc_d  = acc_sum - A_W'(H_ACT);
        gray_d = gray_cur + G_W'(GINC_Q + 1);
      end else begin
        acc_d  = acc_sum;
        gray_d = gray_cur + G_W'(GINC_Q);
      end
    end

    band_cur = band_q;
    if (line_st) band_cur = (vcnt == CNT_W'(V_BLANK)) ? '0 : span_step(band_q, BAND_H, V_BANDS - 1);
    band_d = band_cur;

    // stage 1: pattern select
    act_p1_d = act;
    case (mode_q)
      3'd0:    pat_p1_d = bar_rgb(bar_cur.idx[2:0], band_cur.idx[0]);
      3'd1:    pat_p1_d = {3{sat_gray(gray_cur)}};
      3'd2:    pat_p1_d = chk ? {RGB_W{1'b1}} : '0;
      3'd3:    pat_p1_d = bar_rgb(scr_cur.bar.idx[2:0], band_cur.idx[0]);
      3'd4:    pat_p1_d = solid_q;
      default: pat_p1_d = '0;
    endcase

    // stage 2: blanking gate
    rgb_p2_d = act_p1_q ? pat_p1_q : '0;
    de_p2_d  = act_p1_q;
  end

  always_ff @(posedge PCK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q   <= '0;
      solid_q  <= '0;
      off_q    <= '0;
      scr_q    <= '0;
      bar_q    <= '0;
      band_q   <= '0;
      acc_q    <= '0;
      gray_q   <= '0;
      pat_p1_q <= '0;
      act_p1_q <= 1'b0;
      rgb_p2_q <= '0;
      de_p2_q  <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      solid_q  <= solid_d;
      off_q    <= off_d;
      scr_q    <= scr_d;
      bar_q    <= bar_d;
      band_q   <= band_d;
      acc_q    <= acc_d;
      gray_q   <= gray_d;
      pat_p1_q <= pat_p1_d;
      act_p1_q <= act_p1_d;
      rgb_p2_q <= rgb_p2_d;
      de_p2_q  <= de_p2_d;
    end
  end

  assign vid.VGA_R  = rgb_p2_q[RGB_W-1 -: COLOR_W];
  assign vid.VGA_G  = rgb_p2_q[2*COLOR_W-1 -: COLOR_W];
  assign vid.VGA_B  = rgb_p2_q[COLOR_W-1:0];
  assign vid.DE_OUT = de_p2_q;

endmodule

// File: tb/tb_ptngen_multi.sv
// Scoreboard bench for ptngen_multi on a reduced raster: a driver pushes the
// expected pixel per issued count pair, a monitor pops and compares two edges later.
module tb_ptngen_multi;

  localparam int CNT_W       = 6;
  localparam int COLOR_W     = 4;
  localparam int H_BLANK     = 8;
  localparam int H_TOTAL     = 48;
  localparam int V_BLANK     = 2;
  localparam int V_TOTAL     = 22;
  localparam int NUM_BARS    = 6;
  localparam int V_BANDS     = 3;
  localparam int CHK_LOG2    = 2;
  localparam int SCROLL_STEP = 3;
  localparam int H_ACT       = H_TOTAL - H_BLANK;
  localparam int BAR_W       = H_ACT / NUM_BARS;
  localparam int BAND_H      = (V_TOTAL - V_BLANK) / V_BANDS;
  localparam int RGB_W       = 3 * COLOR_W;
  localparam int CMAX        = (1 << CNT_W) - 1;

  typedef struct {
    logic             de;
    logic [RGB_W-1:0] rgb;
    bit               chk;
    int               h;
    int               v;
    int               mode;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t q[$];
  int   n_checks;
  int   n_err;
  int   m_mode;
  int   m_off;
  int   sync_st;
  logic [RGB_W-1:0] m_solid;

  ptngen_multi_if #(.CNT_W(CNT_W), .COLOR_W(COLOR_W)) vif ();

  ptngen_multi #(
    .CNT_W(CNT_W), .COLOR_W(COLOR_W), .H_BLANK(H_BLANK), .H_TOTAL(H_TOTAL),
    .V_BLANK(V_BLANK), .V_TOTAL(V_TOTAL), .NUM_BARS(NUM_BARS), .V_BANDS(V_BANDS),
    .CHK_LOG2(CHK_LOG2), .SCROLL_STEP(SCROLL_STEP)
  ) dut (
    .PCK  (clk),
    .RST_N(rst_n),
    .vid  (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pattern rules in plain arithmetic: divisions for bar/band/gray, modulo for scroll.
  function automatic logic [RGB_W:0] model_pix(int h, int v, int mode, logic [RGB_W-1:0] solid, int off);
    int x, y, xs, bar, band, g, c;
    logic [COLOR_W-1:0] full, zero;
    logic [RGB_W-1:0]   rgb;
    full = '1;
    zero = '0;
    if (h < H_BLANK || h >= H_TOTAL || v < V_BLANK || v >= V_TOTAL) return '0;
    x = h - H_BLANK;
    y = v - V_BLANK;
    band = y / BAND_H;
    if (band > V_BANDS - 1) band = V_BANDS - 1;
    case (mode)
      0, 3: begin
        xs  = (mode == 3) ? (x + off) % H_ACT : x;
        bar = xs / BAR_W;
        if (bar > NUM_BARS - 1) bar = NUM_BARS - 1;
        c = 7 - (bar % 8);
        if (band % 2 == 1) c = 7 - c;
        rgb = {((c & 4) != 0) ? full : zero, ((c & 2) != 0) ? full : zero, ((c & 1) != 0) ? full : zero};
      end
      1: begin
        g = (x * (1 << COLOR_W)) / H_ACT;
        if (g > (1 << COLOR_W) - 1) g = (1 << COLOR_W) - 1;
        rgb = {3{COLOR_W'(g)}};
      end
      2: rgb = ((((x >> CHK_LOG2) ^ (y >> CHK_LOG2)) & 1) != 0) ? {3{full}} : '0;
      4: rgb = solid;
      default: rgb = '0;
    endcase
    return {1'b1, rgb};
  endfunction

  task automatic check_out(input string name, input logic [RGB_W:0] want);
    logic [RGB_W:0] got;
    got = {vif.DE_OUT, vif.VGA_R, vif.VGA_G, vif.VGA_B};
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got de/rgb=%h, want %h", name, got, want);
    end
  endtask

  task automatic drive(input int h, input int v);
    exp_t e;
    logic [RGB_W:0] p;
    bit act_line;
    @(posedge clk);
    #1;
    vif.HCNT = CNT_W'(h);
    vif.VCNT = CNT_W'(v);
    act_line = (h == H_BLANK) && (v >= V_BLANK) && (v < V_TOTAL);
    if (h == 0 && v == 0) begin
      m_mode  = int'(vif.MODE);
      m_solid = vif.SOLID_RGB;
      m_off   = (m_off + SCROLL_STEP) % H_ACT;
      sync_st = 0;
    end else if (act_line && sync_st == 1) begin
      sync_st = 2;
    end else if (act_line && sync_st == 2) begin
      sync_st = 3;
    end
    p = model_pix(h, v, m_mode, m_solid, m_off);
    e.de   = p[RGB_W];
    e.rgb  = p[RGB_W-1:0];
    e.chk  = (sync_st == 0) || (sync_st == 2);
    e.h    = h;
    e.v    = v;
    e.mode = m_mode;
    q.push_back(e);
  endtask

  task automatic run_frame(input int mode, input bit do_rst);
    int chg_at, idx, rcnt;
    vif.MODE      = 3'(mode);
    vif.SOLID_RGB = RGB_W'($urandom);
    chg_at = $urandom_range(0, H_TOTAL * V_TOTAL - 1);
    idx  = 0;
    rcnt = 0;
    for (int v = 0; v < V_TOTAL; v++) begin
      for (int h = 0; h < H_TOTAL; h++) begin
        drive(h, v);
        if (idx == chg_at) begin
          vif.MODE      = 3'($urandom);
          vif.SOLID_RGB = RGB_W'($urandom);
        end
        if (do_rst && v == 3 && h == 20) begin
          #2;
          rst_n = 1'b0;
          q.delete();
          sync_st = 1;
          m_mode  = 0;
          m_solid = '0;
          m_off   = 0;
          #1;
          check_out("async_reset_clears_outputs", '0);
          rcnt = 3;
        end else if (rcnt > 0) begin
          rcnt--;
          if (rcnt == 0) begin
            #3;
            rst_n = 1'b1;
          end
        end
        idx++;
      end
      // Occasional out-of-range count pairs between lines must read as blanking.
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) drive($urandom_range(H_TOTAL, CMAX), $urandom_range(0, CMAX));
        else                           drive($urandom_range(0, CMAX), $urandom_range(V_TOTAL, CMAX));
      end
    end
  endtask

  always @(negedge clk) begin
    if (q.size() >= 3) begin
      exp_t e;
      logic [RGB_W:0] got;
      e   = q.pop_front();
      got = {vif.DE_OUT, vif.VGA_R, vif.VGA_G, vif.VGA_B};
      if (e.chk) begin
        n_checks++;
        if (got !== {e.de, e.rgb}) begin
          n_err++;
          $display("FAIL pixel mode=%0d h=%0d v=%0d: got de/rgb=%h, want %h",
                   e.mode, e.h, e.v, got, {e.de, e.rgb});
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_err    = 0;
    m_mode   = 0;
    m_off    = 0;
    m_solid  = '0;
    sync_st  = 0;
    rst_n    = 1'b0;
    vif.HCNT = CNT_W'(CMAX);
    vif.VCNT = CNT_W'(CMAX);
    vif.MODE = 3'd0;
    vif.SOLID_RGB = '0;
    repeat (3) @(negedge clk);
    check_out("reset_state", '0);
    @(negedge clk);
    check_out("reset_state_hold", '0);
    rst_n = 1'b1;

    run_frame(0, 1'b0);
    run_frame(1, 1'b0);
    run_frame(2, 1'b0);
    run_frame(4, 1'b0);
    for (int f = 0; f < 40; f++) run_frame(3, 1'b0);
    for (int f = 0; f < 7; f++) run_frame($urandom_range(0, 7), 1'b0);
    run_frame(0, 1'b1);
    run_frame($urandom_range(0, 4), 1'b0);
    run_frame(3, 1'b0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
